// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp sequence monitor: lamp encodings,
// fault cause codes, monitor FSM states and lamp-order helpers.
package lamp_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_SEQ     = 2'b10;
  localparam logic [1:0] FC_DWELL   = 2'b11;

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  // Next lamp in the fixed cyclic order R -> G -> Y -> R.
  function automatic logic [2:0] lamp_successor(input logic [2:0] lamp);
    logic [2:0] nxt;
    case (lamp)
      LAMP_RED:    nxt = LAMP_GREEN;
      LAMP_GREEN:  nxt = LAMP_YELLOW;
      LAMP_YELLOW: nxt = LAMP_RED;
      default:     nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  // Only the three one-hot codes are legal lamp values.
  function automatic logic lamp_is_legal(input logic [2:0] lamp);
    return (lamp == LAMP_RED) || (lamp == LAMP_GREEN) || (lamp == LAMP_YELLOW);
  endfunction

endpackage

// File: rtl/lamp_dwell_timer.sv
// Saturating dwell counter. Counts consecutive identical lamp samples;
// restart loads 1 (first sample of a new lamp), hold adds one more sample.
// timeout is high once the count has reached MAX_DWELL.
module lamp_dwell_timer #(
  parameter int MAX_DWELL = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_hold,
  output logic o_timeout
);

  localparam int DW = $clog2(MAX_DWELL + 1);
  localparam logic [DW-1:0] MaxVal = DW'(MAX_DWELL);

  logic [DW-1:0] r_dwell;

  // Load on a new lamp, otherwise count repeats and stick at the limit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dwell <= '0;
    end else if (i_restart) begin
      r_dwell <= DW'(1);
    end else if (i_hold && (r_dwell != MaxVal)) begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  assign o_timeout = (r_dwell == MaxVal);

endmodule

// File: rtl/lamp_sequence_monitor.sv
// Lamp sequence monitor: checks the RGY lamp bus for one-hot encoding and
// R->G->Y->R order, latches the first fault cause and counts Y->R cycles.
// Build option: define LAMP_MON_DWELL_EN to add the per-lamp dwell timeout.
module lamp_sequence_monitor #(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_light,
  input  logic             i_clr,
  output logic             o_locked,
  output logic             o_fault,
  output logic [1:0]       o_fault_code,
  output logic [CNT_W-1:0] o_cycle_count
);

  import lamp_pkg::*;

  if (MAX_DWELL < 1) begin : g_bad_dwell
    $error("lamp_sequence_monitor: MAX_DWELL must be at least 1");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_prev;
  logic [2:0]       w_next_prev;
  logic [1:0]       r_code;
  logic [1:0]       w_next_code;
  logic [CNT_W-1:0] r_count;
  logic             w_count_inc;
  logic             w_legal;
  logic             w_same;
  logic             w_succ;
  logic             w_timeout;

  assign w_legal = lamp_is_legal(i_light);
  assign w_same  = (i_light == r_prev);
  assign w_succ  = (i_light == lamp_successor(r_prev));

`ifdef LAMP_MON_DWELL_EN
  logic w_restart;
  logic w_hold;
  logic w_timer_rst;

  assign w_restart   = !i_clr && w_legal &&
                       ((r_state == SYNC) || ((r_state == TRACK) && w_succ));
  assign w_hold      = !i_clr && w_legal && (r_state == TRACK) && w_same;
  assign w_timer_rst = i_rst || i_clr;

  lamp_dwell_timer #(
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .i_clk     (i_clk),
    .i_rst     (w_timer_rst),
    .i_restart (w_restart),
    .i_hold    (w_hold),
    .o_timeout (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Monitor state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision; clr beats anything detected on the same sample.
  always_comb begin
    w_next_state = r_state;
    w_next_prev  = r_prev;
    w_next_code  = r_code;
    w_count_inc  = 1'b0;
    if (i_clr) begin
      w_next_state = SYNC;
      w_next_code  = FC_NONE;
    end else begin
      case (r_state)
        SYNC: begin
          if (w_legal) begin
            w_next_state = TRACK;
            w_next_prev  = i_light;
          end
        end
        TRACK: begin
          if (!w_legal) begin
            w_next_state = FAULT;
            w_next_code  = FC_ILLEGAL;
          end else if (w_same) begin
            if (w_timeout) begin
              w_next_state = FAULT;
              w_next_code  = FC_DWELL;
            end
          end else if (w_succ) begin
            w_next_prev = i_light;
            w_count_inc = (r_prev == LAMP_YELLOW);
          end else begin
            w_next_state = FAULT;
            w_next_code  = FC_SEQ;
          end
        end
        FAULT: begin
          w_next_state = FAULT;
        end
        default: begin
          w_next_state = SYNC;
        end
      endcase
    end
  end

  // Last legal lamp, latched fault cause and completed-cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev  <= 3'b000;
      r_code  <= FC_NONE;
      r_count <= '0;
    end else begin
      r_prev <= w_next_prev;
      r_code <= w_next_code;
      if (w_count_inc) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Status outputs decoded straight from registers.
  always_comb begin
    o_locked      = (r_state == TRACK);
    o_fault       = (r_state == FAULT);
    o_fault_code  = r_code;
    o_cycle_count = r_count;
  end

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed bench for lamp_sequence_monitor. A second instance with a 2-bit
// counter shares the same stimulus to exercise counter wrap.
// Expectations for the dwell case follow LAMP_MON_DWELL_EN.
module tb_lamp_sequence_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic       clk;
  logic       rst;
  logic [2:0] light;
  logic       clr;
  logic       locked;
  logic       fault;
  logic [1:0] faultCode;
  logic [7:0] cycleCount;
  logic       w2Locked;
  logic       w2Fault;
  logic [1:0] w2FaultCode;
  logic [1:0] w2CycleCount;

  int vectorCount;
  int missCount;

  lamp_sequence_monitor #(
    .CNT_W     (8),
    .MAX_DWELL (8)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_light       (light),
    .i_clr         (clr),
    .o_locked      (locked),
    .o_fault       (fault),
    .o_fault_code  (faultCode),
    .o_cycle_count (cycleCount)
  );

  lamp_sequence_monitor #(
    .CNT_W     (2),
    .MAX_DWELL (8)
  ) u_dut_w2 (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_light       (light),
    .i_clr         (clr),
    .o_locked      (w2Locked),
    .o_fault       (w2Fault),
    .o_fault_code  (w2FaultCode),
    .o_cycle_count (w2CycleCount)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one sample between edges, then settle just after the rising edge.
  task automatic applyStimulus(input logic [2:0] l, input logic c, input logic r);
    @(negedge clk);
    light = l;
    clr   = c;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Main directed sequence.
  initial begin
    logic expDwellFault;
    vectorCount = 0;
    missCount   = 0;
    light = 3'b000;
    clr   = 1'b0;
    rst   = 1'b0;

    // Reset state
    applyStimulus(3'b000, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_code", 32'(faultCode), 32'd0);
    checkOutput("rst_count", 32'(cycleCount), 32'd0);
    checkOutput("rst_w2_count", 32'(w2CycleCount), 32'd0);

    // Four full cycles: main counts to 4, 2-bit counter wraps to 0
    applyStimulus(R, 1'b0, 1'b0);
    checkOutput("wrap_lock", 32'(locked), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(G, 1'b0, 1'b0);
      applyStimulus(Y, 1'b0, 1'b0);
      applyStimulus(R, 1'b0, 1'b0);
      if (i == 3) checkOutput("wrap_w2_three", 32'(w2CycleCount), 32'd3);
    end
    checkOutput("wrap_main_count", 32'(cycleCount), 32'd4);
    checkOutput("wrap_w2_count", 32'(w2CycleCount), 32'd0);
    checkOutput("wrap_w2_fault", 32'(w2Fault), 32'd0);

    // Reset mid-TRACK with clr and a legal lamp on the same edge
    applyStimulus(G, 1'b1, 1'b1);
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    checkOutput("midrst_fault", 32'(fault), 32'd0);
    checkOutput("midrst_code", 32'(faultCode), 32'd0);
    checkOutput("midrst_count", 32'(cycleCount), 32'd0);
    checkOutput("midrst_w2_locked", 32'(w2Locked), 32'd0);

    // Legal run R,G,Y,R,G,Y,R
    applyStimulus(R, 1'b0, 1'b0);
    checkOutput("run_lock_first", 32'(locked), 32'd1);
    checkOutput("run_count_first", 32'(cycleCount), 32'd0);
    begin
      logic [2:0] seq [6];
      seq = '{G, Y, R, G, Y, R};
      for (int i = 0; i < 6; i++) begin
        applyStimulus(seq[i], 1'b0, 1'b0);
        checkOutput("run_fault", 32'(fault), 32'd0);
        if (i == 2) checkOutput("run_count_one", 32'(cycleCount), 32'd1);
      end
    end
    checkOutput("run_count_two", 32'(cycleCount), 32'd2);
    checkOutput("run_locked", 32'(locked), 32'd1);

    // Sequence error R -> Y, then count frozen
    applyStimulus(Y, 1'b0, 1'b0);
    checkOutput("seq_fault", 32'(fault), 32'd1);
    checkOutput("seq_code", 32'(faultCode), 32'd2);
    checkOutput("seq_locked", 32'(locked), 32'd0);
    applyStimulus(R, 1'b0, 1'b0);
    applyStimulus(G, 1'b0, 1'b0);
    applyStimulus(Y, 1'b0, 1'b0);
    applyStimulus(R, 1'b0, 1'b0);
    checkOutput("seq_count_frozen", 32'(cycleCount), 32'd2);
    checkOutput("seq_code_held", 32'(faultCode), 32'd2);

    // Clear while faulted, then relock on R
    applyStimulus(G, 1'b1, 1'b0);
    checkOutput("clr_fault", 32'(fault), 32'd0);
    checkOutput("clr_locked", 32'(locked), 32'd0);
    checkOutput("clr_code", 32'(faultCode), 32'd0);
    checkOutput("clr_count", 32'(cycleCount), 32'd2);
    applyStimulus(R, 1'b0, 1'b0);
    checkOutput("clr_relock", 32'(locked), 32'd1);

    // clr together with an illegal sample in TRACK: no fault
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("clrill_fault", 32'(fault), 32'd0);
    checkOutput("clrill_locked", 32'(locked), 32'd0);

    // 000 while in SYNC is tolerated
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b000, 1'b0, 1'b0);
      checkOutput("sync_zero_fault", 32'(fault), 32'd0);
      checkOutput("sync_zero_locked", 32'(locked), 32'd0);
    end

    // Illegal encoding in TRACK
    applyStimulus(R, 1'b0, 1'b0);
    applyStimulus(3'b011, 1'b0, 1'b0);
    checkOutput("ill_fault", 32'(fault), 32'd1);
    checkOutput("ill_code", 32'(faultCode), 32'd1);
    applyStimulus(R, 1'b1, 1'b0);

    // Dwell: G held for 20 samples after R
`ifdef LAMP_MON_DWELL_EN
    expDwellFault = 1'b1;
`else
    expDwellFault = 1'b0;
`endif
    applyStimulus(R, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(G, 1'b0, 1'b0);
      if (i == 8) checkOutput("dwell_eight_fault", 32'(fault), 32'd0);
      if (i == 9) begin
        checkOutput("dwell_nine_fault", 32'(fault), 32'(expDwellFault));
        checkOutput("dwell_nine_code", 32'(faultCode), expDwellFault ? 32'd3 : 32'd0);
      end
      if (i == 20) checkOutput("dwell_twenty_fault", 32'(fault), 32'(expDwellFault));
    end
    checkOutput("dwell_count", 32'(cycleCount), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/lamp_sequence_monitor.md
# lamp_sequence_monitor

Checker that sits directly downstream of the cyclic lamp driver. Each clock it samples the driver's 3-bit RGY lamp bus and verifies legal one-hot encoding, the fixed cyclic order R→G→Y→R, and optionally a maximum dwell time per lamp. Detected faults are latched with a cause code, and completed lamp cycles are counted for status reporting.

## Interface
- CNT_W, 8: width of `cycle_count`.
- MAX_DWELL, 8: maximum number of consecutive identical samples allowed per lamp. Must be ≥ 1.
- clk  input  1  system clock; all logic acts on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- light  input  3  lamp bus from the driver. Bit 2 = Red, bit 1 = Green, bit 0 = Yellow.
- clr  input  1  synchronous fault clear / resync request.
- locked  output  1  1 while in TRACK.
- fault  output  1  sticky fault flag.
- fault_code  output  2  cause code:
  - 00: none
  - 01: illegal encoding
  - 10: sequence error
  - 11: dwell timeout
- cycle_count  output  CNT_W  number of completed Y→R transitions; wraps modulo 2^CNT_W.

## Operation
- Legal codes are R = 100, G = 010 and Y = 001. Any other value (000, 011, 101, 110, 111) is illegal.
- Internal registers:
  - `prev`: last legal sample, 3 bits.
  - `dwell`: width $clog2(MAX_DWELL+1); saturates at MAX_DWELL.
- Reset values: state = SYNC, locked = 0, fault = 0, fault_code = 00, cycle_count = 0, prev = 000, dwell = 0.
- FSM states: SYNC, TRACK, FAULT.
- SYNC:
  - Legal sample: go to TRACK, prev ← sample, dwell ← 1.
  - Illegal sample: stay in SYNC; no fault is raised (start-up tolerance).
- TRACK, evaluated in this priority order:
  1. Illegal encoding: go to FAULT, code 01.
  2. Sample == prev: dwell ← dwell+1. If the dwell check is enabled and dwell == MAX_DWELL before the increment, go to FAULT with code 11.
  3. Sample is the legal successor of prev (R→G, G→Y, Y→R): prev ← sample, dwell ← 1. If the transition is Y→R, cycle_count ← cycle_count+1.
  4. Any other legal value (R→Y, G→R, Y→G): go to FAULT, code 10.
- FAULT:
  - fault = 1; fault_code holds the first cause.
  - Later samples are ignored. cycle_count is frozen.
- clr: in any state, go to SYNC with fault ← 0, code ← 00, dwell ← 0. cycle_count is retained. clr has priority over any fault detected on the same edge.
- rst has priority over clr.

## Timing
- All outputs are registered. A fault caused by the sample taken at edge N is visible on `fault`/`fault_code` just after edge N, i.e. one cycle of latency from `light`.
- `locked` rises after the first legal sample edge.
- `cycle_count` updates on the same edge that samples the R following a Y.
- A lamp may hold for exactly MAX_DWELL consecutive samples. The (MAX_DWELL+1)th identical sample faults.
- Wrap: `cycle_count` goes from 2^CNT_W−1 to 0 with no flag.
- Reset asserted mid-operation returns every output to its reset value on that edge, regardless of `light` or `clr`.

## Configuration
- LAMP_MON_DWELL_EN:
  - Defined: the dwell counter and the timeout check (code 11) are built.
  - Undefined: no dwell counter is built, code 11 is never produced, and identical samples are always accepted in TRACK.
- All other behaviour is identical in both builds.

## Structure
- Package `lamp_pkg` holds:
  - Lamp encodings LAMP_RED = 3'b100, LAMP_GREEN = 3'b010, LAMP_YELLOW = 3'b001.
  - Fault-code constants FC_NONE, FC_ILLEGAL, FC_SEQ, FC_DWELL.
  - FSM state typedef (SYNC/TRACK/FAULT).
  - Successor function mapping R→G→Y→R.
- Sub-module `lamp_dwell_timer`:
  - Saturating dwell counter with a `timeout` output; ports clk, rst, restart, hold.
  - Instantiated only under LAMP_MON_DWELL_EN.

## Test plan
- Legal run: reset, then light = R,G,Y,R,G,Y,R one sample each → locked = 1 after the first edge, cycle_count = 2, fault = 0 throughout.
- Sequence error: in TRACK, R then Y → fault = 1 and fault_code = 10 after the Y edge; cycle_count frozen thereafter.
- Illegal encoding: in TRACK, apply 011 → fault_code = 01. With 000 applied only in SYNC → no fault, locked stays 0.
- Dwell: MAX_DWELL = 8, G held 8 samples → no fault; 9th G → fault_code = 11. Repeat with LAMP_MON_DWELL_EN undefined and G held 20 samples → fault = 0.
- Clear:
  - clr while faulted → next cycle fault = 0, locked = 0, cycle_count unchanged; a following R relocks.
  - clr on the same edge as an illegal sample → no fault.
- Reset/wrap:
  - CNT_W = 2, 4 full cycles → cycle_count = 0.
  - rst mid-TRACK → all outputs return to reset values on that edge.
